uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Frames bytes from the UART receiver into configuration writes for the SDR datapath (tuning words, gains, mode registers).
- Sits between the receiver's byte-valid/byte outputs and the register file or NCO configuration bus.
- Recognises a sync byte, an address byte, DATA_BYTES data bytes and a checksum byte.
- Presents each complete frame as one valid/ready write transaction, with inter-byte timeout and error counting.

Parameters:
- SYNC_BYTE, 8'hAA, frame start marker.
- DATA_BYTES, 4, data bytes per frame (1..8); data is sent MSB byte first.
- TIMEOUT_CLKS, 2000000, maximum osc_clk cycles allowed between bytes inside a frame. Roughly 15 ms at 136 MHz. Minimum 2.

Ports:
- osc_clk  in  1  system clock; the receiver byte strobe is synchronous to it.
- rst  in  1  asynchronous reset, active-high.
- i_Rx_DV  in  1  one-cycle byte-valid strobe from the receiver.
- i_Rx_Byte  in  8  received byte; qualified by i_Rx_DV.
- o_cfg_addr  out  8  register address of the pending write.
- o_cfg_data  out  DATA_BYTES*8  register data of the pending write.
- o_cfg_valid  out  1  write request; held until accepted.
- i_cfg_ready  in  1  consumer accepts the write when o_cfg_valid && i_cfg_ready.
- o_frame_err  out  1  one-cycle pulse on any frame error.
- o_err_count  out  8  saturating error count.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): every output is 0, state is IDLE, and the byte index, timeout counter and checksum accumulator are cleared. Reset mid-frame or mid-write discards the frame and drops o_cfg_valid immediately.

State machine: IDLE, ADDR, DATA, CSUM, WRITE.
- IDLE:
  - i_Rx_DV with byte == SYNC_BYTE -> ADDR; timeout counter is cleared.
  - Any other byte is ignored silently; it is not an error.
- ADDR:
  - On i_Rx_DV: latch o_cfg_addr, csum = byte, byte index = 0 -> DATA.
- DATA:
  - On i_Rx_DV: shift the byte into the data register (data = {data[..-8], byte}) and csum ^= byte.
  - After DATA_BYTES bytes -> CSUM.
- CSUM:
  - On i_Rx_DV, byte == csum -> WRITE.
  - Otherwise -> IDLE with a frame error; no write is issued.
- WRITE:
  - o_cfg_valid = 1. Address and data stay stable and unchanged until the handshake completes.
  - In the cycle valid && ready are both high, the transfer occurs. Next cycle: o_cfg_valid = 0, state IDLE.
  - Back-to-back frames are accepted once IDLE is reached.
- Latency: o_cfg_valid rises on the first edge after the cycle in which the checksum byte's i_Rx_DV is high. A ready held high completes the transfer in that same valid cycle.

Timeout (ADDR, DATA, CSUM only):
- The counter increments every cycle and clears on i_Rx_DV.
- When count == TIMEOUT_CLKS-1 with no i_Rx_DV: -> IDLE with a frame error.
- If i_Rx_DV coincides with the terminal count, the byte wins and no error is raised.
- The counter is held at 0 in IDLE and WRITE.

Overrun:
- i_Rx_DV while in WRITE: the byte is dropped and a frame error is raised. The state stays WRITE and the pending write is unaffected.

Frame error:
- o_frame_err pulses for exactly 1 cycle.
- o_err_count increments and saturates at 255; it never wraps.
- Simultaneous error sources in one cycle count once.

Optional Feature:
- UART_CMD_CSUM_EN:
  - Defined: the CSUM state and checksum check are present, as described above.
  - Undefined: the frame is sync + addr + data only. DATA -> WRITE directly after the last data byte, with no checksum logic or state encoding. Timeout and overrun behaviour are unchanged.

Decomposition:
- Package uart_cmd_pkg holds:
  - the state encoding localparams (IDLE=0, ADDR=1, DATA=2, CSUM=3, WRITE=4);
  - default SYNC_BYTE;
  - the error-counter width;
  - a frame-length function of DATA_BYTES.
- One natural sub-module: uart_cmd_timeout, a load/clear/expire counter parameterised by TIMEOUT_CLKS with inputs clr and en and output expired.

Test Plan:
- Good frame:
  - Stimulus: AA, 10, 12, 34, 56, 78, csum 0x10^0x12^0x34^0x56^0x78 = 0x18, with i_cfg_ready held 1.
  - Response: o_cfg_valid for 1 cycle with addr 10, data 32'h12345678; o_err_count stays 0.
- Bad checksum:
  - Stimulus: same frame with csum 0x19.
  - Response: no o_cfg_valid, 1 o_frame_err pulse, o_err_count = 1, o_busy = 0 afterwards.
- Timeout:
  - Stimulus: AA, 10, 12, then silence for TIMEOUT_CLKS cycles (test value 50).
  - Response: error pulse exactly 49 cycles after the last DV, state IDLE. A following good frame is then written correctly.
- Backpressure and overrun:
  - Stimulus: good frame with i_cfg_ready = 0 for 20 cycles; inject one DV byte 0x55 during the wait.
  - Response: addr and data stable throughout, 1 error pulse, the write completes when ready rises, count = 1.
- Noise and sync:
  - Stimulus: bytes 00, FF, 3C, then a good frame.
  - Response: no errors from the noise bytes, exactly one write.
- Reset and saturation:
  - Stimulus: assert rst mid-DATA; then drive 300 bad-checksum frames.
  - Response: after reset, outputs are 0 and the state is IDLE; after the 300 bad frames, o_err_count = 255.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer.
// UART_CMD_CSUM_EN adds the checksum byte and the CSUM state encoding.
package uart_cmd_pkg;

  localparam logic [2:0] STATE_IDLE  = 3'd0;
  localparam logic [2:0] STATE_ADDR  = 3'd1;
  localparam logic [2:0] STATE_DATA  = 3'd2;
  localparam logic [2:0] STATE_CSUM  = 3'd3;
  localparam logic [2:0] STATE_WRITE = 3'd4;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;
  localparam int         ERR_CNT_W         = 8;

`ifdef UART_CMD_CSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = STATE_IDLE,
    ST_ADDR  = STATE_ADDR,
    ST_DATA  = STATE_DATA,
`ifdef UART_CMD_CSUM_EN
    ST_CSUM  = STATE_CSUM,
`endif
    ST_WRITE = STATE_WRITE
  } state_t;

  // Total bytes on the wire for one command frame.
  function automatic int frame_len(input int data_bytes);
    return 2 + data_bytes + CSUM_BYTES;
  endfunction

  // States in which the inter-byte timeout is armed.
  function automatic logic state_timed(input state_t s);
`ifdef UART_CMD_CSUM_EN
    return (s == ST_ADDR) || (s == ST_DATA) || (s == ST_CSUM);
`else
    return (s == ST_ADDR) || (s == ST_DATA);
`endif
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Configuration write bus: address/data qualified by a valid/ready handshake.
// Transfer happens in any cycle where o_cfg_valid && i_cfg_ready; the master
// holds address and data stable while valid is high and ready is low.
interface uart_cmd_parser_if #(
  parameter int DATA_BYTES = 4
);
  logic [7:0]              o_cfg_addr;
  logic [DATA_BYTES*8-1:0] o_cfg_data;
  logic                    o_cfg_valid;
  logic                    i_cfg_ready;

  modport master (
    output o_cfg_addr,
    output o_cfg_data,
    output o_cfg_valid,
    input  i_cfg_ready
  );

  modport slave (
    input  o_cfg_addr,
    input  o_cfg_data,
    input  o_cfg_valid,
    output i_cfg_ready
  );
endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter: counts cycles since the last byte while enabled.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CLKS = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CLKS);

  logic [CW-1:0] r_count;

  // A byte restarts the window with its own cycle already counted, so the
  // terminal count lands TIMEOUT_CLKS-1 cycles after the byte strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!en) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= CW'(1);
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = !clr && (r_count == CW'(TIMEOUT_CLKS - 1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames receiver bytes (sync, addr, data MSB first, optional checksum) into cfg writes.
// Build option: UART_CMD_CSUM_EN enables the trailing XOR checksum byte.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         DATA_BYTES   = 4,
  parameter int         TIMEOUT_CLKS = 2000000
) (
  input  logic                 osc_clk,
  input  logic                 rst,
  input  logic                 i_Rx_DV,
  input  logic [7:0]           i_Rx_Byte,
  uart_cmd_parser_if.master    cfg,
  output logic                 o_frame_err,
  output logic [ERR_CNT_W-1:0] o_err_count,
  output logic                 o_busy,
  output state_t               o_state
);
  localparam int DW = DATA_BYTES * 8;
  localparam int IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  state_t               r_state;
  state_t               w_next;
  logic [IW-1:0]        r_idx;
  logic [7:0]           r_addr;
  logic [DW-1:0]        r_data;
  logic [DW-1:0]        w_data_shift;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_err;
  logic                 w_expired;
  logic                 w_timer_en;
  logic                 w_last_data;
`ifdef UART_CMD_CSUM_EN
  logic [7:0]           r_csum;
`endif

  if (DATA_BYTES > 1) begin : g_shift
    assign w_data_shift = {r_data[DW-9:0], i_Rx_Byte};
  end else begin : g_single
    assign w_data_shift = i_Rx_Byte;
  end

  assign w_last_data = (r_idx == IW'(DATA_BYTES - 1));
  assign w_timer_en  = state_timed(w_next);

  uart_cmd_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk    (osc_clk),
    .rst    (rst),
    .clr    (i_Rx_DV),
    .en     (w_timer_en),
    .expired(w_expired)
  );

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        if (i_Rx_DV) begin
          w_next = ST_DATA;
        end else if (w_expired) begin
          w_next = ST_IDLE;
          w_err  = 1'b1;
        end
      end
      ST_DATA: begin
        if (i_Rx_DV) begin
`ifdef UART_CMD_CSUM_EN
          if (w_last_data) w_next = ST_CSUM;
`else
          if (w_last_data) w_next = ST_WRITE;
`endif
        end else if (w_expired) begin
          w_next = ST_IDLE;
          w_err  = 1'b1;
        end
      end
`ifdef UART_CMD_CSUM_EN
      ST_CSUM: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == r_csum) begin
            w_next = ST_WRITE;
          end else begin
            w_next = ST_IDLE;
            w_err  = 1'b1;
          end
        end else if (w_expired) begin
          w_next = ST_IDLE;
          w_err  = 1'b1;
        end
      end
`endif
      ST_WRITE: begin
        // A byte arriving while the write is pending is an overrun; it is dropped.
        if (i_Rx_DV) w_err = 1'b1;
        if (cfg.i_cfg_ready) w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge osc_clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_err_cnt <= '0;
`ifdef UART_CMD_CSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
      if ((r_state == ST_ADDR) && i_Rx_DV) begin
        r_addr <= i_Rx_Byte;
        r_idx  <= '0;
`ifdef UART_CMD_CSUM_EN
        r_csum <= i_Rx_Byte;
`endif
      end
      if ((r_state == ST_DATA) && i_Rx_DV) begin
        r_data <= w_data_shift;
        r_idx  <= r_idx + 1'b1;
`ifdef UART_CMD_CSUM_EN
        r_csum <= r_csum ^ i_Rx_Byte;
`endif
      end
    end
  end

  assign cfg.o_cfg_addr  = r_addr;
  assign cfg.o_cfg_data  = r_data;
  assign cfg.o_cfg_valid = (r_state == ST_WRITE);
  assign o_frame_err     = w_err;
  assign o_err_count     = r_err_cnt;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_state         = r_state;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames plus randomized frames
// against a frame-level reference model (expected-write queue, error counters).
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int         DB   = 4;
  localparam int         DW   = DB * 8;
  localparam int         TO   = 50;
  localparam logic [7:0] SYNC = 8'hAA;

  logic       clk;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       frame_err;
  logic [7:0] err_count;
  logic       busy;
  state_t     dbg_state;

  uart_cmd_parser_if #(.DATA_BYTES(DB)) cfg ();

  uart_cmd_parser #(
    .SYNC_BYTE   (SYNC),
    .DATA_BYTES  (DB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .osc_clk    (clk),
    .rst        (rst),
    .i_Rx_DV    (rx_dv),
    .i_Rx_Byte  (rx_byte),
    .cfg        (cfg),
    .o_frame_err(frame_err),
    .o_err_count(err_count),
    .o_busy     (busy),
    .o_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int              n_checks = 0;
  int              n_fail   = 0;
  logic [DW+7:0]   exp_q[$];
  int              m_err    = 0;
  int              m_pulses = 0;
  int              ready_mode = 1;

  int              cyc = 0;
  int              last_dv_cyc = 0;
  int              last_err_cyc = 0;
  int              err_pulses = 0;
  int              writes = 0;
  int              valid_cycles = 0;
  int              last_valid_cycles = 0;
  bit              prev_valid = 1'b0;
  logic [7:0]      held_addr;
  logic [DW-1:0]   held_data;
  logic [DW+7:0]   exp_w;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_error();
    m_pulses++;
    if (m_err < 255) m_err++;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_err_count"}, 64'(err_count), 64'(m_err));
    check({tag, "_err_pulses"}, 64'(err_pulses), 64'(m_pulses));
  endtask

  // ---------------- ready driver ----------------
  initial begin
    cfg.i_cfg_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       cfg.i_cfg_ready = 1'b0;
        1:       cfg.i_cfg_ready = 1'b1;
        default: cfg.i_cfg_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_valid = 1'b0;
      err_pulses = 0;
      exp_q.delete();
    end else begin
      if (cfg.o_cfg_valid) begin
        if (!prev_valid) begin
          held_addr    = cfg.o_cfg_addr;
          held_data    = cfg.o_cfg_data;
          valid_cycles = 0;
          check("valid_latency", 64'(cyc - last_dv_cyc), 64'd1);
        end else begin
          check("addr_stable", 64'(cfg.o_cfg_addr), 64'(held_addr));
          check("data_stable", 64'(cfg.o_cfg_data), 64'(held_data));
        end
        valid_cycles++;
        if (cfg.i_cfg_ready) begin
          writes++;
          last_valid_cycles = valid_cycles;
          check("write_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            check("write_addr", 64'(cfg.o_cfg_addr), 64'(exp_w[DW+7:DW]));
            check("write_data", 64'(cfg.o_cfg_data), 64'(exp_w[DW-1:0]));
          end
        end
      end
      prev_valid = cfg.o_cfg_valid && !cfg.i_cfg_ready;
      if (rx_dv) last_dv_cyc = cyc;
      if (frame_err) begin
        err_pulses++;
        last_err_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_dv   = 1'b0;
  endtask

  // Sends one frame with random inter-byte gaps in [gap_lo, gap_hi] idle cycles.
  // Consecutive strobes are gap+2 cycles apart; a spacing of TO or more times out,
  // in which case the rest of the frame is withheld.
  task automatic send_frame(input logic [7:0] addr, input logic [DW-1:0] data,
                            input logic [7:0] csum_flip, input int gap_lo, input int gap_hi);
    logic [7:0] bytes[$];
    int         g;
    bit         timed_out;
`ifdef UART_CMD_CSUM_EN
    logic [7:0] cs;
    cs = addr;
`endif
    bytes.delete();
    bytes.push_back(SYNC);
    bytes.push_back(addr);
    for (int i = DB - 1; i >= 0; i--) begin
      bytes.push_back(data[i*8 +: 8]);
`ifdef UART_CMD_CSUM_EN
      cs = cs ^ data[i*8 +: 8];
`endif
    end
`ifdef UART_CMD_CSUM_EN
    bytes.push_back(cs ^ csum_flip);
`endif
    check("frame_len", 64'(bytes.size()), 64'(frame_len(DB)));
    timed_out = 1'b0;
    for (int i = 0; i < bytes.size(); i++) begin
      g = (i == 0) ? 0 : int'($urandom_range(gap_hi, gap_lo));
      if (g + 2 >= TO) begin
        timed_out = 1'b1;
        idle(TO + 2);
        break;
      end
      idle(g);
      send_byte(bytes[i]);
    end
    if (timed_out || (csum_flip != 8'h00)) model_error();
    else exp_q.push_back({addr, data});
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && (n < limit)) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #2;
    rst      = 1'b1;
    m_err    = 0;
    m_pulses = 0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(cfg.o_cfg_valid), 64'd0);
    check({tag, "_addr"},  64'(cfg.o_cfg_addr),  64'd0);
    check({tag, "_data"},  64'(cfg.o_cfg_data),  64'd0);
    check({tag, "_err"},   64'(frame_err),       64'd0);
    check({tag, "_count"}, 64'(err_count),       64'd0);
    check({tag, "_busy"},  64'(busy),            64'd0);
    check({tag, "_state"}, 64'(dbg_state),       64'(STATE_IDLE));
  endtask

  // ---------------- main sequence ----------------
  int            base;
  logic [7:0]    r_addr;
  logic [DW-1:0] r_data;
  logic [7:0]    r_flip;
  int            r_lo;
  int            r_hi;

  initial begin
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Good frame with ready held high: one-cycle valid.
    base = writes;
    send_frame(8'h10, 32'h12345678, 8'h00, 0, 0);
    wait_idle(50);
    check("good_writes", 64'(writes - base), 64'd1);
    check("good_valid_cycles", 64'(last_valid_cycles), 64'd1);
    check("good_err_count", 64'(err_count), 64'd0);
    check_counts("good");

`ifdef UART_CMD_CSUM_EN
    // Checksum 0x19 instead of 0x18.
    base = writes;
    send_frame(8'h10, 32'h12345678, 8'h01, 0, 0);
    idle(3);
    @(negedge clk);
    check("badcs_writes", 64'(writes - base), 64'd0);
    check("badcs_busy", 64'(busy), 64'd0);
    check("badcs_err_count", 64'(err_count), 64'd1);
    check_counts("badcs");
`endif

    // Timeout after AA 10 12.
    send_byte(SYNC);
    send_byte(8'h10);
    send_byte(8'h12);
    model_error();
    idle(60);
    @(negedge clk);
    check("timeout_delay", 64'(last_err_cyc - last_dv_cyc), 64'(TO - 1));
    check("timeout_state", 64'(dbg_state), 64'(STATE_IDLE));
    check_counts("timeout");
    base = writes;
    send_frame(8'h21, 32'hCAFEF00D, 8'h00, 0, 3);
    wait_idle(50);
    check("post_timeout_writes", 64'(writes - base), 64'd1);

    // Backpressure with an overrun byte during the pending write.
    ready_mode = 0;
    base = writes;
    send_frame(8'h10, 32'h12345678, 8'h00, 0, 0);
    idle(5);
    send_byte(8'h55);
    model_error();
    idle(14);
    @(negedge clk);
    check("bp_valid_held", 64'(cfg.o_cfg_valid), 64'd1);
    check("bp_pending", 64'(writes - base), 64'd0);
    ready_mode = 1;
    wait_idle(50);
    check("bp_writes", 64'(writes - base), 64'd1);
    check_counts("bp");

    // Noise bytes in IDLE then a good frame.
    base = writes;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    send_frame(8'h42, 32'h0BADBEEF, 8'h00, 0, 2);
    wait_idle(50);
    check("noise_writes", 64'(writes - base), 64'd1);
    check_counts("noise");

    // Reset mid-DATA.
    send_byte(SYNC);
    send_byte(8'h10);
    send_byte(8'h12);
    assert_reset();
    #1;
    check_reset_outputs("rst_data");
    release_reset();

    // Reset while a write is pending: valid drops without a clock edge.
    ready_mode = 0;
    send_frame(8'h77, 32'h01020304, 8'h00, 0, 0);
    @(negedge clk);
    check("rst_write_valid_before", 64'(cfg.o_cfg_valid), 64'd1);
    assert_reset();
    #1;
    check_reset_outputs("rst_write");
    ready_mode = 1;
    release_reset();

    // Randomized frames, random ready, occasional near-boundary gaps.
    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      r_addr = 8'($urandom_range(0, 255));
      r_data = DW'($urandom);
      r_flip = 8'h00;
`ifdef UART_CMD_CSUM_EN
      if ($urandom_range(0, 3) == 0) r_flip = 8'($urandom_range(1, 255));
`endif
      if ($urandom_range(0, 3) == 3) begin
        r_lo = TO - 6;
        r_hi = TO;
      end else begin
        r_lo = 0;
        r_hi = 4;
      end
      send_frame(r_addr, r_data, r_flip, r_lo, r_hi);
      wait_idle(200);
    end
    check_counts("random");
    check("random_queue_drained", 64'(exp_q.size()), 64'd0);
    ready_mode = 1;

    // Saturation of the error counter.
    assert_reset();
    release_reset();
    for (int f = 0; f < 300; f++) begin
`ifdef UART_CMD_CSUM_EN
      send_frame(8'h10, 32'h12345678, 8'h01, 0, 0);
`else
      send_frame(8'h10, 32'h12345678, 8'h00, TO, TO);
`endif
      idle(2);
    end
    @(negedge clk);
    check("sat_err_count", 64'(err_count), 64'd255);
    check_counts("sat");
    check("sat_state", 64'(dbg_state), 64'(STATE_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
